// File: rtl/cache_ctrl_burst.sv
// Write-back cache controller: tag check, burst write-back of dirty victims and burst
// line fill from lower memory, with saturating hit/miss/write-back counters.
module cache_ctrl_burst #(
    parameter int WORDS  = 4,
    parameter int WSEL_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_cpu,
    input  logic              wr_cpu,
    input  logic [WSEL_W-1:0] word_sel,
    input  logic [3:0]        be_cpu,
    input  logic              hit,
    input  logic              dirty,
    input  logic              rdy_low,
    input  logic              clr_cnt,
    output logic              rdy_cpu,
    output logic              req_low,
    output logic              wr_low,
    output logic [WSEL_W-1:0] beat_idx,
    output logic [WORDS-1:0]  en_word,
    output logic [3:0]        en_byte,
    output logic              fill_sel,
    output logic              tag_wr,
    output logic              valid_new,
    output logic              dirty_new,
    output logic              asel,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);

    typedef enum logic [1:0] {IDLE, TAG, WB, FILL} state_t;

    state_t            state, state_next;
    logic [WSEL_W-1:0] beat, beat_next;
    logic              last_beat;
    logic              miss_evt, wb_evt;

    assign last_beat = rdy_low && (beat == WSEL_W'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    always_comb begin
        state_next = state;
        beat_next  = beat;
        rdy_cpu    = 1'b0;
        req_low    = 1'b0;
        wr_low     = 1'b0;
        beat_idx   = '0;
        en_word    = '0;
        en_byte    = '0;
        fill_sel   = 1'b0;
        tag_wr     = 1'b0;
        valid_new  = 1'b0;
        dirty_new  = 1'b0;
        asel       = 1'b0;
        case (state)
            IDLE: state_next = TAG;
            TAG: begin
                if (req_cpu) begin
                    if (hit) begin
                        rdy_cpu = 1'b1;
                        if (wr_cpu) begin
                            en_word   = WORDS'(1) << word_sel;
                            en_byte   = be_cpu;
                            tag_wr    = 1'b1;
                            valid_new = 1'b1;
                            dirty_new = 1'b1;
                        end
                    end else if (dirty) begin
                        state_next = WB;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            WB: begin
                req_low  = 1'b1;
                wr_low   = 1'b1;
                asel     = 1'b1;
                beat_idx = beat;
                if (rdy_low) begin
                    if (last_beat) begin
                        state_next = FILL;
                        beat_next  = '0;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end
            FILL: begin
                req_low  = 1'b1;
                fill_sel = 1'b1;
                beat_idx = beat;
                if (rdy_low) begin
                    en_word = WORDS'(1) << beat;
                    en_byte = 4'b1111;
                    if (last_beat) begin
                        tag_wr     = 1'b1;
                        valid_new  = 1'b1;
                        state_next = TAG;
                        beat_next  = '0;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign miss_evt = (state == TAG) && ((state_next == WB) || (state_next == FILL));
    assign wb_evt   = (state == WB) && (state_next == FILL);

    // Clear has priority over any same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else if (clr_cnt) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (rdy_cpu && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 1'b1;
            if (miss_evt && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 1'b1;
            if (wb_evt && (wb_cnt != '1))
                wb_cnt <= wb_cnt + 1'b1;
        end
    end

endmodule
